// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - bit-serial adder/subtractor sequencing one 1-bit cell LSB first
module serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] acc;
    logic [CW-1:0]    cnt;
    logic             cb;
    logic             mode_q;

    logic             last_bit;
    logic             accept;
    logic             cell_s;
    logic             cell_cb;
    logic [WIDTH-1:0] acc_full;

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign accept   = start && (state == IDLE || state == DONE);

    // One full-adder / full-subtractor cell; mode picks carry or borrow.
    always_comb begin
        cell_s = a_sh[0] ^ b_sh[0] ^ cb;
        if (mode_q) begin
            cell_cb = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & cb) | (b_sh[0] & cb);
        end else begin
            cell_cb = (a_sh[0] & b_sh[0]) | (b_sh[0] & cb) | (a_sh[0] & cb);
        end
    end

    // New bit enters at the MSB; after WIDTH shifts the word is LSB-aligned.
    assign acc_full = {cell_s, acc};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            cnt    <= '0;
            cb     <= 1'b0;
            mode_q <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            mode_q <= mode;
            acc    <= '0;
            cnt    <= '0;
            cb     <= 1'b0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            acc  <= acc_full[WIDTH-1:1];
            cb   <= cell_cb;
            cnt  <= cnt + CW'(1);
            if (last_bit) begin
                result <= acc_full;
                cout   <= cell_cb;
            end
        end
    end
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb/tb_serial_addsub_ctrl.sv - self-checking bench for serial_addsub_ctrl with arithmetic reference
module tb_serial_addsub_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;

    int           n_tests = 0;
    int           n_fail = 0;
    logic [W-1:0] cur_r = '0;
    logic         cur_c = 1'b0;

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .result(result),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_res"}, {24'd0, result}, {24'd0, cur_r});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, cur_c});
    endtask

    // Issues one operation and follows it cycle by cycle to its done pulse.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tm,
                         input bit noise, input bit hold);
        logic [W:0]   wide;
        logic [W-1:0] exp_r;
        logic         exp_c;
        if (tm == 1'b0) begin
            wide  = {1'b0, ta} + {1'b0, tb};
            exp_r = wide[W-1:0];
            exp_c = wide[W];
        end else begin
            exp_r = ta - tb;
            exp_c = (ta < tb);
        end
        start = 1'b1;
        a     = ta;
        b     = tb;
        mode  = tm;
        tick();
        if (!hold) start = 1'b0;
        for (int k = 0; k < W; k++) begin
            if (noise) begin
                start = 1'($urandom);
                a     = W'($urandom);
                b     = W'($urandom);
                mode  = ~mode;
            end
            check("run_busy", {31'd0, busy}, 32'd1);
            check("run_done", {31'd0, done}, 32'd0);
            check("run_hold_res", {24'd0, result}, {24'd0, cur_r});
            check("run_hold_cout", {31'd0, cout}, {31'd0, cur_c});
            tick();
        end
        if (!hold) start = 1'b0;
        check("done_pulse", {31'd0, done}, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd0);
        check("done_res", {24'd0, result}, {24'd0, exp_r});
        check("done_cout", {31'd0, cout}, {31'd0, exp_c});
        cur_r = exp_r;
        cur_c = exp_c;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check_idle("reset");
        rst = 1'b0;
        tick();
        check_idle("post_reset");

        // Basic add and single-pulse done
        do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
        tick();
        check_idle("after_add");

        // Overflow and borrow
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        tick();
        do_op(8'h3C, 8'h5A, 1'b1, 1'b0, 1'b0);
        tick();

        // Equal subtract with noisy inputs during RUN
        do_op(8'h5A, 8'h5A, 1'b1, 1'b1, 1'b0);
        tick();
        check_idle("noise_single_done");
        tick();
        check_idle("noise_idle");

        // Back-to-back with start held high
        for (int i = 0; i < 3; i++) do_op(8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
        start = 1'b0;
        tick();
        check_idle("b2b_end");

        // Reset mid-operation
        start = 1'b1;
        a     = 8'h77;
        b     = 8'h22;
        mode  = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        cur_r = '0;
        cur_c = 1'b0;
        check_idle("midop_reset");
        for (int k = 0; k < W + 3; k++) begin
            tick();
            check("no_done_after_reset", {31'd0, done}, 32'd0);
        end
        do_op(8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
        tick();

        // Randomized operations with random idle gaps
        for (int i = 0; i < 500; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                tick();
                check_idle("rand_gap");
            end
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end
        tick();
        check_idle("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
